// File: rtl/axi_error_slave_if.sv
// rtl/axi_error_slave_if.sv - AXI channel bundle with master/slave modports
interface axi_channel #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int USER_W = 1
);
  logic [ID_W-1:0]     aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic                aw_valid;
  logic                aw_ready;

  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic                w_valid;
  logic                w_ready;

  logic [ID_W-1:0]     b_id;
  logic [1:0]          b_resp;
  logic [USER_W-1:0]   b_user;
  logic                b_valid;
  logic                b_ready;

  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic                ar_valid;
  logic                ar_ready;

  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic [USER_W-1:0]   r_user;
  logic                r_valid;
  logic                r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_error_slave.sv
// rtl/axi_error_slave.sv - terminating AXI slave answering every access with a fixed error
module axi_error_slave #(
  parameter logic [1:0] RESP = 2'b11
) (
  input  logic      clk,
  input  logic      rst,
  axi_channel.slave master
);
  localparam int ID_W = $bits(master.aw_id);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  w_state_e        w_state_q, w_state_d;
  logic            aw_ready_q, aw_ready_d;
  logic            w_ready_q, w_ready_d;
  logic            b_valid_q, b_valid_d;
  logic [ID_W-1:0] b_id_q, b_id_d;

  r_state_e        r_state_q, r_state_d;
  logic            ar_ready_q, ar_ready_d;
  logic            r_valid_q, r_valid_d;
  logic            r_last_q, r_last_d;
  logic [ID_W-1:0] r_id_q, r_id_d;
  logic [7:0]      cnt_q, cnt_d;

  // Payload fields have no effect on an error response; fold them into a sink.
  logic unused_inputs;
  assign unused_inputs = ^{master.aw_addr, master.aw_len, master.aw_size, master.aw_burst,
                           master.w_data, master.w_strb,
                           master.ar_addr, master.ar_size, master.ar_burst};

  assign master.aw_ready = aw_ready_q;
  assign master.w_ready  = w_ready_q;
  assign master.b_valid  = b_valid_q;
  assign master.b_id     = b_id_q;
  assign master.b_resp   = RESP;
  assign master.b_user   = '0;
  assign master.ar_ready = ar_ready_q;
  assign master.r_valid  = r_valid_q;
  assign master.r_last   = r_last_q;
  assign master.r_id     = r_id_q;
  assign master.r_resp   = RESP;
  assign master.r_data   = '0;
  assign master.r_user   = '0;

  // Write path: accept AW, swallow W beats until w_last, then hold B until taken.
  always_comb begin
    w_state_d  = w_state_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    b_valid_d  = b_valid_q;
    b_id_d     = b_id_q;
    case (w_state_q)
      W_IDLE: begin
        aw_ready_d = 1'b1;
        if (master.aw_valid && aw_ready_q) begin
          b_id_d     = master.aw_id;
          aw_ready_d = 1'b0;
          w_ready_d  = 1'b1;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (master.w_valid && w_ready_q && master.w_last) begin
          w_ready_d = 1'b0;
          b_valid_d = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (master.b_ready) begin
          b_valid_d  = 1'b0;
          aw_ready_d = 1'b1;
          w_state_d  = W_IDLE;
        end
      end
      default: begin
        w_state_d  = W_IDLE;
        aw_ready_d = 1'b0;
        w_ready_d  = 1'b0;
        b_valid_d  = 1'b0;
      end
    endcase
  end

  // Read path: accept AR, then stream ar_len+1 beats with r_last on the final one.
  always_comb begin
    r_state_d  = r_state_q;
    ar_ready_d = ar_ready_q;
    r_valid_d  = r_valid_q;
    r_last_d   = r_last_q;
    r_id_d     = r_id_q;
    cnt_d      = cnt_q;
    case (r_state_q)
      R_IDLE: begin
        ar_ready_d = 1'b1;
        if (master.ar_valid && ar_ready_q) begin
          r_id_d     = master.ar_id;
          cnt_d      = master.ar_len;
          ar_ready_d = 1'b0;
          r_valid_d  = 1'b1;
          r_last_d   = (master.ar_len == 8'd0);
          r_state_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (master.r_ready) begin
          if (cnt_q != 8'd0) begin
            // Counter counts remaining beats after the current one, so it stops at 0.
            cnt_d    = cnt_q - 8'd1;
            r_last_d = (cnt_q == 8'd1);
          end else begin
            r_valid_d  = 1'b0;
            r_last_d   = 1'b0;
            ar_ready_d = 1'b1;
            r_state_d  = R_IDLE;
          end
        end
      end
      default: begin
        r_state_d  = R_IDLE;
        ar_ready_d = 1'b0;
        r_valid_d  = 1'b0;
        r_last_d   = 1'b0;
      end
    endcase
  end

  // State and handshake registers; reset abandons any outstanding transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_id_q     <= '0;
      cnt_q      <= 8'd0;
    end else begin
      w_state_q  <= w_state_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_id_q     <= b_id_d;
      r_state_q  <= r_state_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_last_q   <= r_last_d;
      r_id_q     <= r_id_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_axi_error_slave.sv
// tb/tb_axi_error_slave.sv - self-checking bench for axi_error_slave
module tb_axi_error_slave;
  localparam int ID_W = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int USER_W = 2;
  localparam logic [1:0] RESP = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_channel #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .USER_W(USER_W)) bus ();

  axi_error_slave #(.RESP(RESP)) dut (
    .clk    (clk),
    .rst    (rst),
    .master (bus)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one write burst; records what the slave did for the caller to judge.
  task automatic write_burst(input int id, input int nbeats, input int early, input int gap_pct,
                             input int b_stall, output int beats, output int bad,
                             output int b_seen, output int b_id_seen, output bit timeout);
    int k;
    int cyc;
    bit hs;
    logic [ID_W-1:0] idv;
    idv = ID_W'(id);
    beats = 0; bad = 0; b_seen = 0; b_id_seen = -1; timeout = 0; cyc = 0; k = 0;
    @(negedge clk);
    bus.w_valid = (early > 0);
    bus.w_last  = (nbeats == 1);
    bus.w_data  = $urandom;
    bus.w_strb  = '1;
    for (int i = 0; i < early; i++) begin
      if (bus.w_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    bus.aw_valid = 1'b1;
    bus.aw_id    = idv;
    bus.aw_len   = 8'(nbeats - 1);
    bus.aw_addr  = $urandom;
    bus.aw_size  = 3'(2);
    bus.aw_burst = 2'b01;
    while (bus.aw_ready !== 1'b1) begin
      if (bus.w_ready !== 1'b0) bad++;
      @(negedge clk);
      if (++cyc > 50) begin timeout = 1; bus.aw_valid = 1'b0; bus.w_valid = 1'b0; return; end
    end
    if (bus.w_ready !== 1'b0) bad++;
    @(negedge clk);
    bus.aw_valid = 1'b0;
    if (bus.w_ready !== 1'b1) bad++;
    cyc = 0;
    while (k < nbeats) begin
      if (bus.b_valid !== 1'b0) bad++;
      if (!bus.w_valid && ($urandom_range(99) >= gap_pct)) begin
        bus.w_valid = 1'b1;
        bus.w_data  = $urandom;
      end
      bus.w_last = (k == nbeats - 1);
      hs = bus.w_valid && bus.w_ready;
      @(negedge clk);
      if (hs) begin k++; bus.w_valid = 1'b0; end
      if (++cyc > 400) begin timeout = 1; bus.w_valid = 1'b0; beats = k; return; end
    end
    beats = k;
    bus.w_last = 1'b0;
    if (bus.w_ready !== 1'b0 || bus.b_valid !== 1'b1) bad++;
    cyc = 0;
    while (bus.b_valid !== 1'b1) begin
      @(negedge clk);
      if (++cyc > 20) begin timeout = 1; return; end
    end
    b_id_seen = int'(bus.b_id);
    if (bus.b_resp !== RESP || bus.b_user !== '0) bad++;
    bus.b_ready = 1'b0;
    for (int i = 0; i < b_stall; i++) begin
      @(negedge clk);
      if (bus.b_valid !== 1'b1 || int'(bus.b_id) != b_id_seen || bus.b_resp !== RESP) bad++;
    end
    bus.b_ready = 1'b1;
    @(negedge clk);
    b_seen = 1;
    if (bus.b_valid !== 1'b0 || bus.aw_ready !== 1'b1 || bus.w_ready !== 1'b0) bad++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.b_valid === 1'b1) b_seen++;
    end
    bus.b_ready = 1'b0;
  endtask

  // Drives one read burst with random r_ready and records beat count and r_last position.
  task automatic read_burst(input int id, input int len, input int rdy_pct, output int beats,
                            output int last_pos, output int bad, output bit timeout);
    int cyc;
    bit hs;
    bit prev_stall;
    logic [ID_W-1:0] idv;
    logic [ID_W-1:0] pid;
    logic plast;
    idv = ID_W'(id);
    beats = 0; last_pos = -1; bad = 0; timeout = 0; cyc = 0; prev_stall = 0;
    pid = '0; plast = 1'b0;
    @(negedge clk);
    bus.ar_valid = 1'b1;
    bus.ar_id    = idv;
    bus.ar_len   = 8'(len);
    bus.ar_addr  = $urandom;
    bus.ar_size  = 3'($urandom_range(0, 2));
    bus.ar_burst = 2'($urandom_range(0, 2));
    while (bus.ar_ready !== 1'b1) begin
      @(negedge clk);
      if (++cyc > 50) begin timeout = 1; bus.ar_valid = 1'b0; return; end
    end
    @(negedge clk);
    bus.ar_valid = 1'b0;
    if (bus.r_valid !== 1'b1) bad++;
    cyc = 0;
    while (bus.r_valid === 1'b1) begin
      if (bus.r_id !== idv || bus.r_resp !== RESP || bus.r_data !== '0 ||
          bus.r_user !== '0 || bus.ar_ready !== 1'b0) bad++;
      if (prev_stall && (bus.r_id !== pid || bus.r_last !== plast)) bad++;
      bus.r_ready = ($urandom_range(99) < rdy_pct);
      hs = bus.r_ready;
      pid = bus.r_id;
      plast = bus.r_last;
      prev_stall = !hs;
      if (hs) begin
        beats++;
        if (bus.r_last === 1'b1) begin
          if (last_pos < 0) last_pos = beats;
          else bad++;
        end
      end
      @(negedge clk);
      if (++cyc > 3000) begin timeout = 1; bus.r_ready = 1'b0; return; end
    end
    if (prev_stall) bad++;
    bus.r_ready = 1'b0;
    if (bus.ar_ready !== 1'b1) bad++;
  endtask

  task automatic test_reset();
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1; bus.w_last = 1'b1; bus.ar_valid = 1'b1;
    bus.b_ready = 1'b1; bus.r_ready = 1'b1; bus.aw_id = '0; bus.ar_id = '0;
    bus.aw_len = '0; bus.ar_len = 8'd3; bus.aw_addr = '0; bus.ar_addr = '0;
    bus.aw_size = '0; bus.ar_size = '0; bus.aw_burst = '0; bus.ar_burst = '0;
    bus.w_data = '0; bus.w_strb = '0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.aw_ready, bus.w_ready, bus.b_valid, bus.ar_ready, bus.r_valid, bus.r_last} !== 6'b0) begin
        failures++;
        $display("FAIL reset_hold: handshakes=%b expected 000000",
                 {bus.aw_ready, bus.w_ready, bus.b_valid, bus.ar_ready, bus.r_valid, bus.r_last});
      end
    end
    checks++;
    if (bus.b_resp !== RESP || bus.r_resp !== RESP || bus.r_data !== '0 ||
        bus.b_user !== '0 || bus.r_user !== '0) begin
      failures++;
      $display("FAIL const_outputs: b_resp=%b r_resp=%b r_data=%h expected %b %b 0",
               bus.b_resp, bus.r_resp, bus.r_data, RESP, RESP);
    end
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.w_last = 1'b0; bus.ar_valid = 1'b0;
    bus.b_ready = 1'b0; bus.r_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.aw_ready, bus.w_ready, bus.b_valid, bus.ar_ready, bus.r_valid, bus.r_last} !== 6'b100100) begin
      failures++;
      $display("FAIL reset_release: handshakes=%b expected 100100",
               {bus.aw_ready, bus.w_ready, bus.b_valid, bus.ar_ready, bus.r_valid, bus.r_last});
    end
  endtask

  task automatic test_single_write();
    int beats, bad, b_seen, b_id_seen;
    bit to;
    write_burst(5, 1, 0, 0, 0, beats, bad, b_seen, b_id_seen, to);
    checks++;
    if (to || bad != 0 || beats != 1) begin
      failures++;
      $display("FAIL single_write: timeout=%0d protocol_errors=%0d beats=%0d expected 0 0 1", to, bad, beats);
    end
    checks++;
    if (b_id_seen != 5 || b_seen != 1) begin
      failures++;
      $display("FAIL single_write_b: b_id=%0d responses=%0d expected 5 1", b_id_seen, b_seen);
    end
  endtask

  task automatic test_write_burst_stall();
    int beats, bad, b_seen, b_id_seen;
    bit to;
    write_burst(7, 4, 0, 50, 4, beats, bad, b_seen, b_id_seen, to);
    checks++;
    if (to || bad != 0 || beats != 4) begin
      failures++;
      $display("FAIL write_burst_stall: timeout=%0d protocol_errors=%0d beats=%0d expected 0 0 4", to, bad, beats);
    end
    checks++;
    if (b_id_seen != 7 || b_seen != 1) begin
      failures++;
      $display("FAIL write_burst_stall_b: b_id=%0d responses=%0d expected 7 1", b_id_seen, b_seen);
    end
  endtask

  task automatic test_w_before_aw();
    int beats, bad, b_seen, b_id_seen;
    bit to;
    write_burst(2, 1, 3, 0, 1, beats, bad, b_seen, b_id_seen, to);
    checks++;
    if (to || bad != 0 || beats != 1 || b_id_seen != 2 || b_seen != 1) begin
      failures++;
      $display("FAIL w_before_aw: timeout=%0d errors=%0d beats=%0d b_id=%0d responses=%0d expected 0 0 1 2 1",
               to, bad, beats, b_id_seen, b_seen);
    end
  endtask

  task automatic test_single_read();
    int beats, last_pos, bad;
    bit to;
    read_burst(9, 0, 100, beats, last_pos, bad, to);
    checks++;
    if (to || bad != 0 || beats != 1 || last_pos != 1) begin
      failures++;
      $display("FAIL single_read: timeout=%0d errors=%0d beats=%0d last_at=%0d expected 0 0 1 1",
               to, bad, beats, last_pos);
    end
  endtask

  task automatic test_long_read_concurrent();
    int rbeats, rlast, rbad, wbeats, wbad, bseen, bid;
    bit rto, wto;
    fork
      read_burst(11, 255, 60, rbeats, rlast, rbad, rto);
      write_burst(6, 5, 0, 30, 2, wbeats, wbad, bseen, bid, wto);
    join
    checks++;
    if (rto || rbad != 0 || rbeats != 256 || rlast != 256) begin
      failures++;
      $display("FAIL long_read: timeout=%0d errors=%0d beats=%0d last_at=%0d expected 0 0 256 256",
               rto, rbad, rbeats, rlast);
    end
    checks++;
    if (wto || wbad != 0 || wbeats != 5 || bid != 6 || bseen != 1) begin
      failures++;
      $display("FAIL concurrent_write: timeout=%0d errors=%0d beats=%0d b_id=%0d responses=%0d expected 0 0 5 6 1",
               wto, wbad, wbeats, bid, bseen);
    end
  endtask

  task automatic test_reset_mid_read();
    int n, beats, last_pos, bad;
    bit to;
    @(negedge clk);
    bus.ar_valid = 1'b1; bus.ar_id = 4'd3; bus.ar_len = 8'd15;
    checks++;
    if (bus.ar_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_ar_ready: got %b expected 1", bus.ar_ready);
    end
    @(negedge clk);
    bus.ar_valid = 1'b0;
    bus.r_ready = 1'b1;
    n = 0;
    while (n < 9 && bus.r_valid === 1'b1) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 9 || bus.r_valid !== 1'b1 || bus.r_last !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_pre: beats=%0d r_valid=%b r_last=%b expected 9 1 0", n, bus.r_valid, bus.r_last);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.r_valid !== 1'b0 || bus.r_last !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_abort: r_valid=%b r_last=%b expected 0 0", bus.r_valid, bus.r_last);
    end
    rst = 1'b0;
    bus.r_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ar_ready !== 1'b1 || bus.aw_ready !== 1'b1 || bus.r_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_release: ar_ready=%b aw_ready=%b r_valid=%b expected 1 1 0",
               bus.ar_ready, bus.aw_ready, bus.r_valid);
    end
    read_burst(4, 1, 70, beats, last_pos, bad, to);
    checks++;
    if (to || bad != 0 || beats != 2 || last_pos != 2) begin
      failures++;
      $display("FAIL mid_reset_new_read: timeout=%0d errors=%0d beats=%0d last_at=%0d expected 0 0 2 2",
               to, bad, beats, last_pos);
    end
  endtask

  task automatic test_random();
    int rid, rlen, wid, wn, rbeats, rlast, rbad, wbeats, wbad, bseen, bid;
    bit rto, wto;
    for (int it = 0; it < 6; it++) begin
      rid = $urandom_range(0, 15);
      rlen = $urandom_range(0, 20);
      wid = $urandom_range(0, 15);
      wn = $urandom_range(1, 8);
      fork
        read_burst(rid, rlen, $urandom_range(30, 100), rbeats, rlast, rbad, rto);
        write_burst(wid, wn, $urandom_range(0, 2), $urandom_range(0, 60), $urandom_range(0, 3),
                    wbeats, wbad, bseen, bid, wto);
      join
      checks++;
      if (rto || rbad != 0 || rbeats != rlen + 1 || rlast != rlen + 1) begin
        failures++;
        $display("FAIL random_read[%0d]: timeout=%0d errors=%0d beats=%0d last_at=%0d expected 0 0 %0d %0d",
                 it, rto, rbad, rbeats, rlast, rlen + 1, rlen + 1);
      end
      checks++;
      if (wto || wbad != 0 || wbeats != wn || bid != wid || bseen != 1) begin
        failures++;
        $display("FAIL random_write[%0d]: timeout=%0d errors=%0d beats=%0d b_id=%0d responses=%0d expected 0 0 %0d %0d 1",
                 it, wto, wbad, wbeats, bid, bseen, wn, wid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_write_burst_stall();
    test_w_before_aw();
    test_single_read();
    test_long_read_concurrent();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
